// File: rtl/bert_mem_pkg.sv
// Shared constants, helper functions and FSM encoding for the BERT memory front-end.
package bert_mem_pkg;

    localparam int unsigned MAX_BUFFER_SEL = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STORE = 2'd1,
        DONE  = 2'd2
    } wb_state_e;

    function automatic int unsigned elems_f(input int unsigned data_width, input int unsigned num_bits);
        return data_width / num_bits;
    endfunction

    function automatic int unsigned wpr_f(input int unsigned cols, input int unsigned elems);
        return cols / elems;
    endfunction

    function automatic int unsigned tile_words_f(input int unsigned tile_rows, input int unsigned wpr);
        return tile_rows * wpr;
    endfunction

    function automatic int unsigned region_words_f(input int unsigned rows, input int unsigned wpr);
        return rows * wpr;
    endfunction

endpackage

// File: rtl/wb_addr_gen.sv
// Row/word counters, per-region tile offset and the row-major/transposed address mux.
module wb_addr_gen
    import bert_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = 16,
    parameter int unsigned WPR           = 24,
    parameter int unsigned TILE_ROWS     = 32,
    parameter int unsigned ORIGINAL_ROWS = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic                  beat_i,
    input  logic                  done_i,
    input  logic                  idle_i,
    input  logic                  clr_i,
    input  logic [2:0]            sel_i,
    input  logic                  tc_i,
    output logic [ADDR_WIDTH-1:0] addr_c,
    output logic                  last_c
);

    localparam int unsigned TILE_WORDS   = tile_words_f(TILE_ROWS, WPR);
    localparam int unsigned REGION_WORDS = region_words_f(ORIGINAL_ROWS, WPR);
    localparam int unsigned ROW_W        = $clog2(TILE_ROWS);
    localparam int unsigned WORD_W       = $clog2(WPR);

    logic [ROW_W-1:0]  row_q, row_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       off_q, off_d;
    logic [31:0]       off_inc;
    logic [31:0]       local_off;
    logic              tc_q, tc_d;
    logic              pend_q, pend_d;

    always_comb begin
        row_d     = row_q;
        word_d    = word_q;
        base_d    = base_q;
        tc_d      = tc_q;
        off_d     = off_q;
        pend_d    = pend_q;
        off_inc   = off_q + TILE_WORDS;
        last_c    = (row_q == ROW_W'(TILE_ROWS - 1)) && (word_q == WORD_W'(WPR - 1));

        if (load_i) begin
            base_d = 32'(sel_i) * REGION_WORDS;
            tc_d   = tc_i;
            row_d  = '0;
            word_d = '0;
        end else if (beat_i) begin
            if (word_q == WORD_W'(WPR - 1)) begin
                word_d = '0;
                row_d  = row_q + ROW_W'(1);
            end else begin
                word_d = word_q + WORD_W'(1);
            end
        end

        // An offset clear seen while busy is deferred to DONE and replaces the advance.
        if (idle_i) begin
            if (clr_i) begin
                off_d = '0;
            end
        end else if (done_i) begin
            off_d  = (pend_q || clr_i || (off_inc >= REGION_WORDS)) ? 32'd0 : off_inc;
            pend_d = 1'b0;
        end else if (clr_i) begin
            pend_d = 1'b1;
        end

        local_off = tc_q ? (32'(word_q) * TILE_ROWS + 32'(row_q))
                         : (32'(row_q) * WPR + 32'(word_q));
        addr_c    = ADDR_WIDTH'(base_q + off_q + local_off);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q  <= '0;
            word_q <= '0;
            base_q <= '0;
            off_q  <= '0;
            tc_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            word_q <= word_d;
            base_q <= base_d;
            off_q  <= off_d;
            tc_q   <= tc_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: rtl/writeback_logic_gen.sv
// Writeback stream-to-BRAM Port A writer: FSM, handshake and registered write port.
// Optional accepted-beat counter enabled by defining WB_BEAT_COUNT_EN.
module writeback_logic_gen
    import bert_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned ORIGINAL_COLUMNS = 768,
    parameter int unsigned ORIGINAL_ROWS    = 512,
    parameter int unsigned NUM_BITS         = 8,
    parameter int unsigned DATA_WIDTH       = 256,
    parameter int unsigned TILE_ROWS        = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_store,
    input  logic                  reset_addr_counter,
    input  logic [2:0]            Buffer_Select,
    input  logic                  Tiles_Control,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    output logic                  store_done,
    output logic                  busy
`ifdef WB_BEAT_COUNT_EN
   ,input  logic                  beat_count_clr,
    output logic [31:0]           beat_count
`endif
);

    localparam int unsigned ELEMS = elems_f(DATA_WIDTH, NUM_BITS);
    localparam int unsigned WPR   = wpr_f(ORIGINAL_COLUMNS, ELEMS);

    wb_state_e             state_q, state_d;
    logic                  beat, load, done_c, idle_c, last_c;
    logic [ADDR_WIDTH-1:0] addr_c;

    logic                  s_ready_q, s_ready_d;
    logic                  bram_en_q, bram_en_d;
    logic [ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_q, bram_din_d;
    logic                  store_done_q, store_done_d;
    logic                  busy_q, busy_d;

    wb_addr_gen #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .WPR           (WPR),
        .TILE_ROWS     (TILE_ROWS),
        .ORIGINAL_ROWS (ORIGINAL_ROWS)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .beat_i (beat),
        .done_i (done_c),
        .idle_i (idle_c),
        .clr_i  (reset_addr_counter),
        .sel_i  (Buffer_Select),
        .tc_i   (Tiles_Control),
        .addr_c (addr_c),
        .last_c (last_c)
    );

    // Next state and next values of the registered write port.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        beat    = s_valid && s_ready_q;
        done_c  = (state_q == DONE);
        idle_c  = (state_q == IDLE);

        unique case (state_q)
            IDLE: begin
                if (start_store && (Buffer_Select <= 3'(MAX_BUFFER_SEL))) begin
                    state_d = STORE;
                    load    = 1'b1;
                end
            end
            STORE: begin
                if (beat && last_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        bram_en_d    = beat;
        bram_addr_d  = beat ? addr_c : bram_addr_q;
        bram_din_d   = beat ? s_data : bram_din_q;
        s_ready_d    = (state_d == STORE);
        store_done_d = (state_d == DONE);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready_q    <= 1'b0;
            bram_en_q    <= 1'b0;
            bram_addr_q  <= '0;
            bram_din_q   <= '0;
            store_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            s_ready_q    <= s_ready_d;
            bram_en_q    <= bram_en_d;
            bram_addr_q  <= bram_addr_d;
            bram_din_q   <= bram_din_d;
            store_done_q <= store_done_d;
            busy_q       <= busy_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign bram_en    = bram_en_q;
    assign bram_we    = bram_en_q;
    assign bram_addr  = bram_addr_q;
    assign bram_din   = bram_din_q;
    assign store_done = store_done_q;
    assign busy       = busy_q;

`ifdef WB_BEAT_COUNT_EN
    logic [31:0] beat_count_q;

    // Clear has priority over a beat in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || beat_count_clr) begin
            beat_count_q <= '0;
        end else if (beat) begin
            beat_count_q <= beat_count_q + 32'd1;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_writeback_logic_gen.sv
// Scoreboard bench for writeback_logic_gen: driver pushes expected writes, negedge monitor pops them.
module tb_writeback_logic_gen;

    localparam int unsigned TILE_WORDS   = 768;
    localparam int unsigned REGION_WORDS = 12288;
    localparam int unsigned WPR          = 24;
    localparam int unsigned TROWS        = 32;

    typedef struct {
        logic [15:0]  addr;
        logic [255:0] din;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst, start_store, reset_addr_counter, Tiles_Control, s_valid;
    logic [2:0]   Buffer_Select;
    logic [255:0] s_data;
    logic         s_ready, bram_en, bram_we, store_done, busy;
    logic [15:0]  bram_addr;
    logic [255:0] bram_din;
`ifdef WB_BEAT_COUNT_EN
    logic         beat_count_clr = 1'b0;
    logic [31:0]  beat_count;
`endif

    int checks = 0;
    int errors = 0;
    wr_t exp_q[$];
    int  done_q[$];
    int  tile_writes = 0;

    // Reference model state.
    int unsigned m_off = 0, m_base = 0, m_k = 0, m_beats = 0;
    bit          m_tc = 0, m_pend = 0;

    writeback_logic_gen dut (
        .clk                (clk),
        .rst                (rst),
        .start_store        (start_store),
        .reset_addr_counter (reset_addr_counter),
        .Buffer_Select      (Buffer_Select),
        .Tiles_Control      (Tiles_Control),
        .s_valid            (s_valid),
        .s_ready            (s_ready),
        .s_data             (s_data),
        .bram_en            (bram_en),
        .bram_we            (bram_we),
        .bram_addr          (bram_addr),
        .bram_din           (bram_din),
        .store_done         (store_done),
        .busy               (busy)
`ifdef WB_BEAT_COUNT_EN
       ,.beat_count_clr     (beat_count_clr),
        .beat_count         (beat_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Expected address of the k-th word of a tile, from row/column position.
    function automatic logic [15:0] exp_addr(input int unsigned k);
        int unsigned row = k / WPR;
        int unsigned col = k % WPR;
        int unsigned local_a = m_tc ? (col * TROWS + row) : k;
        return 16'(m_base + m_off + local_a);
    endfunction

    function automatic logic [255:0] rand_word();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_en"}, bram_en, 0);
        chk({tag, "_we"}, bram_we, 0);
        chk({tag, "_addr"}, bram_addr, 0);
        chk({tag, "_din"}, bram_din, 0);
        chk({tag, "_done"}, store_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ready"}, s_ready, 0);
    endtask

    task automatic start_tile(input logic [2:0] sel, input logic tc, input bit with_clr);
        @(posedge clk); #1;
        Buffer_Select = sel; Tiles_Control = tc;
        start_store = 1'b1; reset_addr_counter = with_clr; s_valid = 1'b0;
        if (with_clr) m_off = 0;
        if (sel <= 3'd4) begin
            m_base = 32'(sel) * REGION_WORDS; m_tc = tc; m_k = 0;
        end
    endtask

    // mode 0 back-to-back with index data, 1 toggling valid, 2 random valid.
    task automatic run_beats(input int n, input int mode, input int clr_at, input int start_at);
        int acc = 0;
        int cyc = 0;
        bit v;
        while (acc < n && cyc < 5000) begin
            @(posedge clk); #1;
            start_store = 1'b0; reset_addr_counter = 1'b0;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 3) != 0);
            s_valid = v;
            s_data = (mode == 0) ? 256'(m_k) : rand_word();
            if (cyc == clr_at) begin reset_addr_counter = 1'b1; m_pend = 1; end
            if (cyc == start_at) start_store = 1'b1;
            if (v && s_ready) begin
                exp_q.push_back('{exp_addr(m_k), s_data});
                m_k++; acc++; m_beats++;
                if (m_k == TILE_WORDS) begin
                    done_q.push_back(1);
                    m_off = (m_pend || (m_off + TILE_WORDS >= REGION_WORDS)) ? 0 : m_off + TILE_WORDS;
                    m_pend = 0;
                end
            end
            cyc++;
        end
        if (acc < n) begin
            checks++; errors++;
            $display("FAIL beat_timeout accepted=%0d required=%0d", acc, n);
        end
        @(posedge clk); #1;
        s_valid = 1'b0; start_store = 1'b0; reset_addr_counter = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 8; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (bram_en || bram_we) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write actual=%0h required=none", bram_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bram_addr, e.addr);
                chk("wr_din", bram_din, e.din);
                chk("wr_en_we", {bram_en, bram_we}, 2'b11);
                tile_writes++;
            end
        end
        if (store_done) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_store_done actual=1 required=0");
            end else begin
                void'(done_q.pop_front());
                chk("done_after_all_writes", tile_writes, TILE_WORDS);
            end
            tile_writes = 0;
        end
        if (rst) tile_writes = 0;
    end

    initial begin
        rst = 1'b1; start_store = 0; reset_addr_counter = 0; Buffer_Select = 0;
        Tiles_Control = 0; s_valid = 0; s_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst = 1'b0;

        // Region 0 row-major, index data.
        start_tile(3'd0, 1'b0, 1'b0);
        run_beats(TILE_WORDS, 0, -1, -1);
        wait_idle("t1");

        // Region 2 transposed, second tile offset.
        start_tile(3'd2, 1'b1, 1'b0);
        run_beats(TILE_WORDS, 2, -1, -1);
        wait_idle("t2");

        // Toggling valid.
        start_tile(3'd0, 1'b0, 1'b0);
        run_beats(TILE_WORDS, 1, -1, -1);
        wait_idle("t3");

        // Region 1: offset wrap, then a deferred clear mid-tile.
        for (int t = 0; t < 17; t++) begin
            start_tile(3'd1, 1'b0, t == 0);
            run_beats(TILE_WORDS, 0, (t == 16) ? 300 : -1, -1);
            wait_idle("t4");
        end
        start_tile(3'd1, 1'b0, 1'b0);
        run_beats(TILE_WORDS, 2, -1, -1);
        wait_idle("t4b");

        // Illegal region, then start during STORE.
        start_tile(3'd6, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start_store = 1'b0; s_valid = 1'b1; s_data = rand_word();
            chk("badsel_busy", busy, 0);
            chk("badsel_ready", s_ready, 0);
        end
        s_valid = 1'b0;
        start_tile(3'd4, 1'b1, 1'b0);
        run_beats(TILE_WORDS, 2, -1, 400);
        wait_idle("t5");

        // Abort after 100 beats, then restart.
        start_tile(3'd3, 1'b0, 1'b1);
        run_beats(100, 0, -1, -1);
        rst = 1'b1;
        m_off = 0; m_pend = 0; m_k = 0; m_beats = 0;
        @(posedge clk); #1;
        check_outputs_zero("midrst");
        rst = 1'b0;
        start_tile(3'd3, 1'b0, 1'b0);
        run_beats(TILE_WORDS, 2, -1, -1);
        wait_idle("t6");

        repeat (4) @(posedge clk);
        #1;
        chk("writes_outstanding", 32'(exp_q.size()), 0);
        chk("done_outstanding", 32'(done_q.size()), 0);
`ifdef WB_BEAT_COUNT_EN
        chk("beat_count", beat_count, m_beats);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
